mem_port_arbiter: RTL and testbench

Arbitrates one shared single-port unified memory between the instruction-fetch stage and the data-memory stage of the 5-stage RV32 pipeline. It sequences each access through a request/accept/response handshake with the memory and drives per-stage stall signals until that stage's access completes. It sits between `IF`/`MEM` and the external memory, in place of the two separate memory ports at top level.

---
 rtl/arb_pkg.sv | 22 ++
 rtl/mem_arb_wdog.sv | 31 +++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the unified instruction/data memory port arbiter.
package arb_pkg;

  // Access sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } arb_state_e;

  // Which requester currently owns the memory port
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  // d_ctrl encoding; 2'b11 is treated as a write
  localparam logic [1:0] MEM_RD = 2'b01;
  localparam logic [1:0] MEM_WR = 2'b10;

endpackage

// File: rtl/mem_arb_wdog.sv
// Access watchdog: counts cycles an access has been outstanding and flags expiry.
// Only instantiated when ARB_TIMEOUT_EN is defined.
module mem_arb_wdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT);

  logic [CntW-1:0] cnt_q;

  // Counter clears on a new grant and saturates at the limit
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign expired = (cnt_q == Limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared unified memory between instruction fetch (I) and data (D).
// Data wins on simultaneous requests; each access runs IDLE -> REQ -> WAIT -> DONE.
// Optional feature: define ARB_TIMEOUT_EN to abort accesses that wait TIMEOUT cycles.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              stall_if,
  input  logic [1:0]        d_ctrl,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err
);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q;
  logic              mem_req_q, mem_we_q, timeout_err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;

  logic d_pending, d_write;
  logic grant, grant_d, capture, tmo_hit;
  logic wdog_clear, wdog_en, wdog_expired;

  assign d_pending = (d_ctrl & (MEM_RD | MEM_WR)) != 2'b00;
  assign d_write   = (d_ctrl & MEM_WR) != 2'b00;

`ifdef ARB_TIMEOUT_EN
  mem_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (wdog_clear),
    .en      (wdog_en),
    .expired (wdog_expired)
  );
`else
  assign wdog_expired = 1'b0;
  logic unused_timeout;
  assign unused_timeout = ^{wdog_clear, wdog_en, TIMEOUT};
`endif

  // State and owner register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
    end else begin
      state_q <= state_d;
      if (grant) owner_q <= grant_d ? OWN_D : OWN_I;
    end
  end

  // Next-state: DONE always returns to IDLE so a stale request cannot be re-granted
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (d_pending || if_req) state_d = REQ;
      REQ: begin
        if (mem_ready)         state_d = WAIT;
        else if (wdog_expired) state_d = DONE;
      end
      WAIT: if (mem_rvalid || wdog_expired) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and control decode from the current state
  always_comb begin
    grant      = (state_q == IDLE) && (d_pending || if_req);
    grant_d    = (state_q == IDLE) && d_pending;
    capture    = (state_q == WAIT) && mem_rvalid;
    // A real handshake in the expiring cycle takes priority over the timeout
    tmo_hit    = wdog_expired && (((state_q == REQ) && !mem_ready) ||
                                  ((state_q == WAIT) && !mem_rvalid));
    wdog_clear = grant;
    wdog_en    = (state_q == REQ) || (state_q == WAIT);
    if_valid   = (state_q == DONE) && (owner_q == OWN_I);
    d_valid    = (state_q == DONE) && (owner_q == OWN_D);
  end

  // Memory request, write data and response capture registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (grant) begin
        mem_req_q  <= 1'b1;
        mem_addr_q <= grant_d ? d_addr : if_addr;
        mem_we_q   <= grant_d && d_write;
        if (grant_d) mem_wdata_q <= d_wdata;
      end
      if ((state_q == REQ) && (mem_ready || tmo_hit)) mem_req_q <= 1'b0;
      if (capture) begin
        if (owner_q == OWN_D) d_rdata_q  <= mem_rdata;
        else                  if_rdata_q <= mem_rdata;
      end
      if (tmo_hit) begin
        if (owner_q == OWN_D) d_rdata_q  <= '0;
        else                  if_rdata_q <= '0;
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign timeout_err = timeout_err_q;
  assign stall_if    = if_req & ~if_valid;
  assign stall_mem   = d_pending & ~d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. Inputs are driven and outputs
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_mem_port_arbiter;
  import arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        stall_if;
  logic [1:0]  d_ctrl;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        stall_mem;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_valid    (if_valid),
    .stall_if    (stall_if),
    .d_ctrl      (d_ctrl),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_valid     (d_valid),
    .stall_mem   (stall_mem),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .timeout_err (timeout_err)
  );

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%0b want=0", mem_req); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%0b want=0", mem_we); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h want=0", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem_wdata got=%h want=0", mem_wdata); end
    total++; if ({if_rdata, d_rdata} !== 64'h0) begin bad++; $display("FAIL rst_rdata got=%h/%h want=0", if_rdata, d_rdata); end
    total++; if ({if_valid, d_valid, timeout_err} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {if_valid, d_valid, timeout_err}); end
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_idle_req got=%0b want=0", mem_req); end
  endtask

  task automatic test_fetch;
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    total++; if (stall_if !== 1'b1) begin bad++; $display("FAIL fetch_stall0 got=%0b want=1", stall_if); end
    @(negedge clk);
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin bad++; $display("FAIL fetch_req got=%0b/%h/%0b want=1/100/0", mem_req, mem_addr, mem_we); end
    mem_ready = 1'b1;
    @(negedge clk);
    total++; if (mem_req !== 1'b0 || if_valid !== 1'b0 || stall_if !== 1'b1) begin bad++; $display("FAIL fetch_wait got=%0b/%0b/%0b want=0/0/1", mem_req, if_valid, stall_if); end
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
    @(negedge clk);
    total++; if (if_valid !== 1'b1 || if_rdata !== 32'h13 || stall_if !== 1'b0) begin bad++; $display("FAIL fetch_done got=%0b/%h/%0b want=1/00000013/0", if_valid, if_rdata, stall_if); end
    total++; if (d_valid !== 1'b0) begin bad++; $display("FAIL fetch_dvalid got=%0b want=0", d_valid); end
    if_req = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    total++; if (if_valid !== 1'b0 || if_rdata !== 32'h13) begin bad++; $display("FAIL fetch_after got=%0b/%h want=0/00000013", if_valid, if_rdata); end
  endtask

  task automatic test_simultaneous;
    if_req = 1'b1; if_addr = 32'h100; d_ctrl = MEM_RD; d_addr = 32'h2000;
    @(negedge clk);
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h2000 || mem_we !== 1'b0) begin bad++; $display("FAIL sim_dfirst got=%0b/%h/%0b want=1/2000/0", mem_req, mem_addr, mem_we); end
    total++; if (stall_if !== 1'b1 || stall_mem !== 1'b1) begin bad++; $display("FAIL sim_stalls got=%0b/%0b want=1/1", stall_if, stall_mem); end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    total++; if (d_valid !== 1'b1 || if_valid !== 1'b0 || d_rdata !== 32'hCAFE_0001) begin bad++; $display("FAIL sim_dvalid got=%0b/%0b/%h want=1/0/cafe0001", d_valid, if_valid, d_rdata); end
    total++; if (stall_mem !== 1'b0) begin bad++; $display("FAIL sim_stall_mem got=%0b want=0", stall_mem); end
    d_ctrl = 2'b00; mem_rvalid = 1'b0;
    @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL sim_no_grant_in_done got=%0b want=0", mem_req); end
    @(negedge clk);
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin bad++; $display("FAIL sim_ifetch got=%0b/%h/%0b want=1/100/0", mem_req, mem_addr, mem_we); end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
    @(negedge clk);
    total++; if (if_valid !== 1'b1 || if_rdata !== 32'h13 || d_rdata !== 32'hCAFE_0001) begin bad++; $display("FAIL sim_ivalid got=%0b/%h/%h want=1/00000013/cafe0001", if_valid, if_rdata, d_rdata); end
    if_req = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_backpressure;
    d_ctrl = MEM_WR; d_addr = 32'h3000; d_wdata = 32'hDEAD_BEEF; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h3000 || mem_wdata !== 32'hDEAD_BEEF) begin
        bad++;
        $display("FAIL st_hold[%0d] got=%0b/%0b/%h/%h want=1/1/3000/deadbeef", i, mem_req, mem_we, mem_addr, mem_wdata);
      end
      if (i == 4) mem_ready = 1'b1;
    end
    @(negedge clk);
    total++; if (mem_req !== 1'b0 || d_valid !== 1'b0 || stall_mem !== 1'b1) begin bad++; $display("FAIL st_accepted got=%0b/%0b/%0b want=0/0/1", mem_req, d_valid, stall_mem); end
    mem_ready = 1'b0;
    @(negedge clk);
    total++; if (d_valid !== 1'b0) begin bad++; $display("FAIL st_wait_ack got=%0b want=0", d_valid); end
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0055;
    @(negedge clk);
    total++; if (d_valid !== 1'b1 || if_valid !== 1'b0) begin bad++; $display("FAIL st_dvalid got=%0b/%0b want=1/0", d_valid, if_valid); end
    d_ctrl = 2'b00; mem_rvalid = 1'b0;
    @(negedge clk);
    total++; if (d_valid !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL st_after got=%0b/%0b want=0/0", d_valid, mem_req); end
  endtask

  task automatic test_reset_mid_wait;
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; if_req = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0077;
    total++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || mem_we !== 1'b0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL rmw_mem got=%0b/%h/%0b/%h want=0/0/0/0", mem_req, mem_addr, mem_we, mem_wdata); end
    total++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin bad++; $display("FAIL rmw_rdata got=%h/%h want=0/0", if_rdata, d_rdata); end
    @(negedge clk);
    total++; if (if_valid !== 1'b0 || d_valid !== 1'b0 || if_rdata !== 32'h0) begin bad++; $display("FAIL rmw_ignored got=%0b/%0b/%h want=0/0/0", if_valid, d_valid, if_rdata); end
    mem_rvalid = 1'b0;
    @(negedge clk);
    total++; if (if_valid !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL rmw_idle got=%0b/%0b want=0/0", if_valid, mem_req); end
  endtask

  task automatic test_back_to_back;
    if_req = 1'b1; if_addr = 32'h0;
    @(negedge clk);
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin bad++; $display("FAIL b2b_req0 got=%0b/%h want=1/0", mem_req, mem_addr); end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0011;
    @(negedge clk);
    total++; if (if_valid !== 1'b1 || if_rdata !== 32'h11) begin bad++; $display("FAIL b2b_done0 got=%0b/%h want=1/00000011", if_valid, if_rdata); end
    if_addr = 32'h4; mem_rvalid = 1'b0;
    @(negedge clk);
    total++; if (mem_req !== 1'b0 || if_valid !== 1'b0) begin bad++; $display("FAIL b2b_no_dup got=%0b/%0b want=0/0", mem_req, if_valid); end
    @(negedge clk);
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin bad++; $display("FAIL b2b_req4 got=%0b/%h want=1/4", mem_req, mem_addr); end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0022;
    @(negedge clk);
    total++; if (if_valid !== 1'b1 || if_rdata !== 32'h22) begin bad++; $display("FAIL b2b_done4 got=%0b/%h want=1/00000022", if_valid, if_rdata); end
    if_req = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    total++; if (mem_req !== 1'b0 || if_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%0b/%0b want=0/0", mem_req, if_valid); end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout;
    int   waited;
    logic seen;
    // Leave a nonzero load value so the forced zero is observable
    d_ctrl = MEM_RD; d_addr = 32'h600;
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    d_ctrl = 2'b00; mem_rvalid = 1'b0;
    @(negedge clk);
    d_ctrl = MEM_RD; d_addr = 32'h500; mem_ready = 1'b0;
    seen = 1'b0; waited = 0;
    for (int i = 1; i <= 30 && !seen; i++) begin
      @(negedge clk);
      if (d_valid) begin seen = 1'b1; waited = i; end
    end
    total++; if (!seen) begin bad++; $display("FAIL tmo_pulse got=none want=d_valid within 30 cycles"); end
    total++; if (seen && (waited < 9 || waited > 10)) begin bad++; $display("FAIL tmo_latency got=%0d want=9..10", waited); end
    total++; if (d_rdata !== 32'h0 || timeout_err !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL tmo_state got=%h/%0b/%0b want=0/1/0", d_rdata, timeout_err, mem_req); end
    d_ctrl = 2'b00;
    repeat (3) @(negedge clk);
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%0b want=1", timeout_err); end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_cleared got=%0b want=0", timeout_err); end
  endtask
`else
  task automatic test_timeout;
    // Without the watchdog a stalled access just keeps waiting
    d_ctrl = MEM_RD; d_addr = 32'h500; mem_ready = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (d_valid !== 1'b0 || mem_req !== 1'b1 || timeout_err !== 1'b0) begin bad++; $display("FAIL notmo_wait got=%0b/%0b/%0b want=0/1/0", d_valid, mem_req, timeout_err); end
    d_ctrl = 2'b00;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    total++; if (mem_req !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL notmo_reset got=%0b/%0b want=0/0", mem_req, timeout_err); end
  endtask
`endif

  initial begin
    reset_n = 1'b0; if_req = 1'b0; if_addr = '0; d_ctrl = 2'b00; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    test_reset();
    test_fetch();
    test_simultaneous();
    test_store_backpressure();
    test_reset_mid_wait();
    test_back_to_back();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
